de_stage: RTL and testbench

Decode stage of the five-stage RV32I pipeline. It is the consumer end of the FE latch: it takes the fetched instruction, PC, pcplus and instruction count, and produces the single-bit stall back to fetch. It decodes the instruction, generates the immediate, reads the architectural register file and detects RAW hazards against AGEX/MEM. It also owns the register-file write port driven by WB, and fills the DE latch consumed by AGEX.

---
 rtl/de_stage_pkg.sv | 110 +++++++++++
 rtl/de_stage_if.sv | 24 ++
 rtl/de_regfile.sv | 39 +++
 rtl/de_stage.sv | 152 +++++++++++++++
 tb/tb_de_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/de_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: latch layouts, op enum,
// opcode/funct encodings and a few op-class helpers.
package de_stage_pkg;

    localparam int DBITS     = 32;
    localparam int INSTBITS  = 32;
    localparam int REGNOBITS = 5;
    localparam int NUMREGS   = 32;

    localparam int FE_latch_WIDTH        = 129;
    localparam int DE_latch_WIDTH        = 237;
    localparam int from_AGEX_to_DE_WIDTH = 7;
    localparam int from_MEM_to_DE_WIDTH  = 6;
    localparam int from_WB_to_DE_WIDTH   = 38;

    typedef enum logic [5:0] {
        OP_INVALID = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LW, OP_SW
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic                valid;
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pcplus;
        logic [DBITS-1:0]    inst_count;
    } fe_latch_t;

    typedef struct packed {
        logic                 br_mispred;
        logic                 wr_en;
        logic [REGNOBITS-1:0] rd;
    } agex_to_de_t;

    typedef struct packed {
        logic                 wr_en;
        logic [REGNOBITS-1:0] rd;
    } mem_to_de_t;

    typedef struct packed {
        logic                 wr_en;
        logic [REGNOBITS-1:0] rd;
        logic [DBITS-1:0]     data;
    } wb_to_de_t;

    typedef struct packed {
        logic                 valid;
        op_e                  op;
        logic [INSTBITS-1:0]  inst;
        logic [DBITS-1:0]     pc;
        logic [DBITS-1:0]     pcplus;
        logic [DBITS-1:0]     rs1_val;
        logic [DBITS-1:0]     rs2_val;
        logic [DBITS-1:0]     imm;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_en;
        logic [DBITS-1:0]     inst_count;
    } de_latch_t;

    function automatic logic op_is_branch(input op_e op);
        return op inside {[OP_BEQ:OP_BGEU]};
    endfunction

    function automatic logic op_writes_rd(input op_e op);
        return (op != OP_INVALID) && !op_is_branch(op) && (op != OP_SW);
    endfunction

    function automatic logic op_uses_rs1(input op_e op);
        return (op != OP_INVALID) && !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic op_uses_rs2(input op_e op);
        return (op inside {[OP_ADD:OP_AND]}) || op_is_branch(op) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/de_stage_if.sv
// Pipeline-side bundle of the decode stage: FE latch in, hazard/writeback
// feedback in, stall to fetch and DE latch out.
interface de_stage_if;
    import de_stage_pkg::*;

    fe_latch_t   fe_latch_in;
    agex_to_de_t from_AGEX_to_DE;
    mem_to_de_t  from_MEM_to_DE;
    wb_to_de_t   from_WB_to_DE;
    logic [0:0]  from_DE_to_FE;
    de_latch_t   DE_latch_out;

    // from_DE_to_FE[0] is the stall: when high, FE must hold its latch and the
    // DE latch carries a bubble; FE contents are consumed only on a cycle it is low.
    modport master (
        output fe_latch_in, from_AGEX_to_DE, from_MEM_to_DE, from_WB_to_DE,
        input  from_DE_to_FE, DE_latch_out
    );

    modport slave (
        input  fe_latch_in, from_AGEX_to_DE, from_MEM_to_DE, from_WB_to_DE,
        output from_DE_to_FE, DE_latch_out
    );
endinterface

// File: rtl/de_regfile.sv
// 32x32 architectural register file: async clear, x0 reads zero, and a
// write-first bypass so a WB write is visible to reads in the same cycle.
module de_regfile
    import de_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REGNOBITS-1:0] wr_rd,
    input  logic [DBITS-1:0]     wr_data,
    input  logic [REGNOBITS-1:0] rs1,
    input  logic [REGNOBITS-1:0] rs2,
    output logic [DBITS-1:0]     rs1_val,
    output logic [DBITS-1:0]     rs2_val
);

    logic [DBITS-1:0] regs [NUMREGS];
    logic             do_write;

    assign do_write = wr_en && (wr_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[wr_rd] <= wr_data;
        end
    end

    function automatic logic [DBITS-1:0] read_port(input logic [REGNOBITS-1:0] rs);
        if (rs == '0)                     return '0;
        else if (do_write && wr_rd == rs) return wr_data;
        else                              return regs[rs];
    endfunction

    assign rs1_val = read_port(rs1);
    assign rs2_val = read_port(rs2);

endmodule

// File: rtl/de_stage.sv
// RV32I decode stage: decodes the FE latch, builds the immediate, reads the
// register file, stalls fetch on AGEX/MEM RAW hazards and fills the DE latch.
module de_stage
    import de_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    de_stage_if.slave    bus
);

    fe_latch_t            fe;
    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [REGNOBITS-1:0] rs1, rs2, rd;
    op_e                  op;
    logic [DBITS-1:0]     imm;
    logic [DBITS-1:0]     rs1_val, rs2_val;
    logic                 use_rs1, use_rs2;
    logic                 hz_rs1, hz_rs2;
    logic                 stall;
    de_latch_t            decoded;
    de_latch_t            latch;

    assign fe     = bus.fe_latch_in;
    assign opcode = fe.inst[6:0];
    assign f3     = fe.inst[14:12];
    assign f7     = fe.inst[31:25];
    assign rs1    = fe.inst[19:15];
    assign rs2    = fe.inst[24:20];
    assign rd     = fe.inst[11:7];

    always_comb begin
        op = OP_INVALID;
        case (opcode)
            OPC_OP: begin
                case (f3)
                    F3_ADD:  op = (f7 == F7_ZERO) ? OP_ADD : (f7 == F7_ALT) ? OP_SUB : OP_INVALID;
                    F3_SLL:  if (f7 == F7_ZERO) op = OP_SLL;
                    F3_SLT:  if (f7 == F7_ZERO) op = OP_SLT;
                    F3_SLTU: if (f7 == F7_ZERO) op = OP_SLTU;
                    F3_XOR:  if (f7 == F7_ZERO) op = OP_XOR;
                    F3_SR:   op = (f7 == F7_ZERO) ? OP_SRL : (f7 == F7_ALT) ? OP_SRA : OP_INVALID;
                    F3_OR:   if (f7 == F7_ZERO) op = OP_OR;
                    F3_AND:  if (f7 == F7_ZERO) op = OP_AND;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_ADD:  op = OP_ADDI;
                    F3_SLT:  op = OP_SLTI;
                    F3_SLTU: op = OP_SLTIU;
                    F3_XOR:  op = OP_XORI;
                    F3_OR:   op = OP_ORI;
                    F3_AND:  op = OP_ANDI;
                    F3_SLL:  if (f7 == F7_ZERO) op = OP_SLLI;
                    F3_SR:   op = (f7 == F7_ZERO) ? OP_SRLI : (f7 == F7_ALT) ? OP_SRAI : OP_INVALID;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_LUI:   op = OP_LUI;
            OPC_AUIPC: op = OP_AUIPC;
            OPC_JAL:   op = OP_JAL;
            OPC_JALR:  if (f3 == F3_JALR) op = OP_JALR;
            OPC_BRANCH: begin
                case (f3)
                    F3_BEQ:  op = OP_BEQ;
                    F3_BNE:  op = OP_BNE;
                    F3_BLT:  op = OP_BLT;
                    F3_BGE:  op = OP_BGE;
                    F3_BLTU: op = OP_BLTU;
                    F3_BGEU: op = OP_BGEU;
                    default: op = OP_INVALID;
                endcase
            end
            OPC_LOAD:  if (f3 == F3_WORD) op = OP_LW;
            OPC_STORE: if (f3 == F3_WORD) op = OP_SW;
            default:   op = OP_INVALID;
        endcase
    end

    // Immediate format follows the major opcode; B and J come out with bit0 clear.
    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:
                imm = {{20{fe.inst[31]}}, fe.inst[31:20]};
            OPC_STORE:
                imm = {{20{fe.inst[31]}}, fe.inst[31:25], fe.inst[11:7]};
            OPC_BRANCH:
                imm = {{19{fe.inst[31]}}, fe.inst[31], fe.inst[7], fe.inst[30:25], fe.inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {fe.inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{fe.inst[31]}}, fe.inst[31], fe.inst[19:12], fe.inst[20], fe.inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    de_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.from_WB_to_DE.wr_en),
        .wr_rd   (bus.from_WB_to_DE.rd),
        .wr_data (bus.from_WB_to_DE.data),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val)
    );

    // WB never appears here: the regfile bypass already delivers its value.
    assign use_rs1 = op_uses_rs1(op) && (rs1 != '0);
    assign use_rs2 = op_uses_rs2(op) && (rs2 != '0);
    assign hz_rs1  = use_rs1 &&
                     ((bus.from_AGEX_to_DE.wr_en && bus.from_AGEX_to_DE.rd == rs1) ||
                      (bus.from_MEM_to_DE.wr_en  && bus.from_MEM_to_DE.rd  == rs1));
    assign hz_rs2  = use_rs2 &&
                     ((bus.from_AGEX_to_DE.wr_en && bus.from_AGEX_to_DE.rd == rs2) ||
                      (bus.from_MEM_to_DE.wr_en  && bus.from_MEM_to_DE.rd  == rs2));
    assign stall   = fe.valid && !bus.from_AGEX_to_DE.br_mispred && (hz_rs1 || hz_rs2);

    always_comb begin
        decoded            = '0;
        decoded.valid      = fe.valid;
        decoded.op         = op;
        decoded.inst       = fe.inst;
        decoded.pc         = fe.pc;
        decoded.pcplus     = fe.pcplus;
        decoded.rs1_val    = rs1_val;
        decoded.rs2_val    = rs2_val;
        decoded.imm        = imm;
        decoded.rd         = rd;
        decoded.wr_en      = op_writes_rd(op) && (rd != '0);
        decoded.inst_count = fe.inst_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            latch <= '0;
        else if (bus.from_AGEX_to_DE.br_mispred || stall || !fe.valid)
            latch <= '0;
        else
            latch <= decoded;
    end

    assign bus.DE_latch_out     = latch;
    assign bus.from_DE_to_FE[0] = stall;

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: decode, immediates, regfile bypass, hazards,
// mispredict squash and asynchronous reset.
module tb_de_stage;
    import de_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    de_stage_if bus();

    de_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fe(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] ic);
        bus.fe_latch_in.valid      = v;
        bus.fe_latch_in.inst       = inst;
        bus.fe_latch_in.pc         = pc;
        bus.fe_latch_in.pcplus     = pc + 32'd4;
        bus.fe_latch_in.inst_count = ic;
    endtask

    task automatic drive_agex(input logic mis, input logic en, input logic [4:0] rd);
        bus.from_AGEX_to_DE.br_mispred = mis;
        bus.from_AGEX_to_DE.wr_en      = en;
        bus.from_AGEX_to_DE.rd         = rd;
    endtask

    task automatic drive_mem(input logic en, input logic [4:0] rd);
        bus.from_MEM_to_DE.wr_en = en;
        bus.from_MEM_to_DE.rd    = rd;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.from_WB_to_DE.wr_en = en;
        bus.from_WB_to_DE.rd    = rd;
        bus.from_WB_to_DE.data  = data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    initial begin
        reset = 1'b1;
        drive_fe(1'b0, 32'h0, 32'h0, 32'h0);
        drive_agex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b0, 5'd0);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Reset before any clock edge
        #2;
        check("reset_latch", bus.DE_latch_out, '0);
        check("reset_stall", bus.from_DE_to_FE, 1'b0);
        #10 reset = 1'b0;

        for (int n = 1; n < 32; n++) begin
            drive_fe(1'b1, r_add(5'd5, 5'(n), 5'(n)), 32'h100, 32'(n));
            tick();
            check($sformatf("rd0_rs1_x%0d", n), bus.DE_latch_out.rs1_val, 32'h0);
            check($sformatf("rd0_rs2_x%0d", n), bus.DE_latch_out.rs2_val, 32'h0);
        end

        // addi x1,x0,5
        drive_fe(1'b1, 32'h00500093, 32'h200, 32'd7);
        tick();
        check("addi_valid", bus.DE_latch_out.valid, 1'b1);
        check("addi_op", bus.DE_latch_out.op, OP_ADDI);
        check("addi_imm", bus.DE_latch_out.imm, 32'd5);
        check("addi_rs1", bus.DE_latch_out.rs1_val, 32'd0);
        check("addi_rd", bus.DE_latch_out.rd, 5'd1);
        check("addi_wr_en", bus.DE_latch_out.wr_en, 1'b1);
        check("addi_pc", bus.DE_latch_out.pc, 32'h200);
        check("addi_pcplus", bus.DE_latch_out.pcplus, 32'h204);
        check("addi_count", bus.DE_latch_out.inst_count, 32'd7);

        // add x3,x2,x0 with WB writing x2 in the same cycle
        drive_fe(1'b1, 32'h000101B3, 32'h204, 32'd8);
        drive_wb(1'b1, 5'd2, 32'hDEADBEEF);
        #1 check("byp_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("byp_rs1", bus.DE_latch_out.rs1_val, 32'hDEADBEEF);
        check("byp_op", bus.DE_latch_out.op, OP_ADD);
        check("byp_rd", bus.DE_latch_out.rd, 5'd3);
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        check("commit_rs1", bus.DE_latch_out.rs1_val, 32'hDEADBEEF);

        // addi x4,x1,1 against AGEX, then MEM, then clear
        drive_fe(1'b1, 32'h00108213, 32'h208, 32'd9);
        drive_agex(1'b0, 1'b1, 5'd1);
        #1 check("hz_agex_stall", bus.from_DE_to_FE, 1'b1);
        tick();
        check("hz_agex_bubble", bus.DE_latch_out.valid, 1'b0);
        drive_agex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b1, 5'd1);
        #1 check("hz_mem_stall", bus.from_DE_to_FE, 1'b1);
        tick();
        check("hz_mem_bubble", bus.DE_latch_out.valid, 1'b0);
        drive_mem(1'b0, 5'd0);
        #1 check("hz_clear_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("hz_clear_valid", bus.DE_latch_out.valid, 1'b1);
        check("hz_clear_op", bus.DE_latch_out.op, OP_ADDI);
        check("hz_clear_imm", bus.DE_latch_out.imm, 32'd1);

        // sw x5,-4(x2): rs2 hazard only through MEM
        drive_fe(1'b1, 32'hFE512E23, 32'h20C, 32'd10);
        drive_mem(1'b1, 5'd5);
        #1 check("hz_rs2_stall", bus.from_DE_to_FE, 1'b1);
        drive_mem(1'b0, 5'd0);
        tick();
        check("sw_op", bus.DE_latch_out.op, OP_SW);
        check("sw_imm", bus.DE_latch_out.imm, 32'hFFFFFFFC);
        check("sw_wr_en", bus.DE_latch_out.wr_en, 1'b0);

        // lui x1,0x12345: rs1 field (x8) busy in AGEX but unused
        drive_fe(1'b1, 32'h123450B7, 32'h210, 32'd11);
        drive_agex(1'b0, 1'b1, 5'd8);
        #1 check("lui_no_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("lui_op", bus.DE_latch_out.op, OP_LUI);
        check("lui_imm", bus.DE_latch_out.imm, 32'h12345000);

        // FE invalid with a would-be hazard
        drive_fe(1'b0, 32'h00108213, 32'h214, 32'd12);
        drive_agex(1'b0, 1'b1, 5'd1);
        #1 check("fe_inv_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("fe_inv_valid", bus.DE_latch_out.valid, 1'b0);

        // Mispredict over a hazard; WB write of x6 still lands
        drive_fe(1'b1, 32'h00108213, 32'h218, 32'd13);
        drive_agex(1'b1, 1'b1, 5'd1);
        drive_wb(1'b1, 5'd6, 32'h00001234);
        #1 check("mis_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("mis_latch", bus.DE_latch_out, '0);
        drive_agex(1'b0, 1'b0, 5'd0);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_fe(1'b1, 32'h006303B3, 32'h21C, 32'd14);
        tick();
        check("mis_wb_rs1", bus.DE_latch_out.rs1_val, 32'h00001234);
        check("mis_wb_rs2", bus.DE_latch_out.rs2_val, 32'h00001234);

        // Illegal instruction
        drive_fe(1'b1, 32'hFFFFFFFF, 32'h220, 32'd15);
        #1 check("ill_stall", bus.from_DE_to_FE, 1'b0);
        tick();
        check("ill_op", bus.DE_latch_out.op, OP_INVALID);
        check("ill_wr_en", bus.DE_latch_out.wr_en, 1'b0);
        check("ill_valid", bus.DE_latch_out.valid, 1'b1);
        check("ill_rd", bus.DE_latch_out.rd, 5'd31);

        // WB to x0 is neither bypassed nor stored
        drive_fe(1'b1, r_add(5'd3, 5'd0, 5'd0), 32'h224, 32'd16);
        drive_wb(1'b1, 5'd0, 32'h0000FFFF);
        tick();
        check("x0_bypass", bus.DE_latch_out.rs1_val, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        check("x0_stored", bus.DE_latch_out.rs2_val, 32'h0);

        // Branch and jump immediates
        drive_fe(1'b1, 32'hFF1FF0E3, 32'h228, 32'd17);
        tick();
        check("bgeu_op", bus.DE_latch_out.op, OP_BGEU);
        check("bgeu_imm", bus.DE_latch_out.imm, 32'hFFFFFFE0);
        check("bgeu_wr_en", bus.DE_latch_out.wr_en, 1'b0);
        drive_fe(1'b1, 32'h00208463, 32'h22C, 32'd18);
        tick();
        check("beq_op", bus.DE_latch_out.op, OP_BEQ);
        check("beq_imm", bus.DE_latch_out.imm, 32'd8);
        drive_fe(1'b1, 32'h0100006F, 32'h230, 32'd19);
        tick();
        check("jal_op", bus.DE_latch_out.op, OP_JAL);
        check("jal_imm", bus.DE_latch_out.imm, 32'd16);
        check("jal_x0_wr_en", bus.DE_latch_out.wr_en, 1'b0);

        // Asynchronous reset between clock edges
        drive_fe(1'b1, 32'h000101B3, 32'h234, 32'd20);
        tick();
        check("pre_rst_valid", bus.DE_latch_out.valid, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_rst_latch", bus.DE_latch_out, '0);
        #2 reset = 1'b0;
        tick();
        check("async_rst_x2", bus.DE_latch_out.rs1_val, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
